// File: rtl/regfile_pkg.sv
// Shared register-file constants: bus widths, register count and the
// enable/reset encodings used along the writeback path.
package regfile_pkg;
  localparam int RegBusW    = 32;
  localparam int RegAddrW   = 5;
  localparam int RegNum     = 32;
  localparam int RegNumLog2 = 5;

  typedef logic [RegBusW-1:0]  RegBus;
  typedef logic [RegAddrW-1:0] RegAddrBus;

  localparam RegBus     ZeroWord    = '0;
  localparam RegAddrBus NOPRegAddr  = '0;
  localparam logic      RstEnable   = 1'b1;
  localparam logic      WriteEnable = 1'b1;
  localparam logic      ReadEnable  = 1'b1;
  localparam logic      ReadDisable = 1'b0;
endpackage

// File: rtl/hilo_reg.sv
// HI/LO special-register pair with same-cycle write-first bypass.
// Storage updates one cycle after hilo write; outputs are combinational, no backpressure.
module hilo_reg
  import regfile_pkg::*;
#(
  parameter int DATA_W = RegBusW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      hi_q <= DATA_W'(ZeroWord);
      lo_q <= DATA_W'(ZeroWord);
    end else if (we == WriteEnable) begin
      hi_q <= hi_i;
      lo_q <= lo_i;
    end
  end

  // Reset dominates the bypass so EX never sees a write that is being discarded.
  always_comb begin
    hi_o = DATA_W'(ZeroWord);
    lo_o = DATA_W'(ZeroWord);
    if (rst != RstEnable) begin
      hi_o = (we == WriteEnable) ? hi_i : hi_q;
      lo_o = (we == WriteEnable) ? lo_i : lo_q;
    end
  end

endmodule

// File: rtl/regfile.sv
// GPR file at the MEM/WB consumer end: two ID read ports with write-first bypass, plus HI/LO.
// Writes land one cycle later; reads are combinational, no backpressure.
module regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RegBusW,
  parameter int ADDR_W   = RegAddrW,
  parameter int NUM_REGS = RegNum
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic              hilo_we,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  logic [DATA_W-1:0] mem [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      mem <= '{default: '0};
    end else if (we == WriteEnable && waddr != ADDR_W'(NOPRegAddr)) begin
      mem[waddr] <= wdata;
    end
  end

  // $0 is checked before the bypass so a retiring write to r0 never leaks through.
  always_comb begin
    rdata1 = DATA_W'(ZeroWord);
    if (rst != RstEnable && re1 == ReadEnable && raddr1 != ADDR_W'(NOPRegAddr)) begin
      if (we == WriteEnable && waddr == raddr1) rdata1 = wdata;
      else                                      rdata1 = mem[raddr1];
    end
  end

  always_comb begin
    rdata2 = DATA_W'(ZeroWord);
    if (rst != RstEnable && re2 == ReadEnable && raddr2 != ADDR_W'(NOPRegAddr)) begin
      if (we == WriteEnable && waddr == raddr2) rdata2 = wdata;
      else                                      rdata2 = mem[raddr2];
    end
  end

  hilo_reg #(
    .DATA_W(DATA_W)
  ) u_hilo (
    .clk  (clk),
    .rst  (rst),
    .we   (hilo_we),
    .hi_i (hi_i),
    .lo_i (lo_i),
    .hi_o (hi_o),
    .lo_o (lo_o)
  );

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios then randomized traffic
// against an array-based architectural model.
module tb_regfile;
  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic        hilo_we;
  logic [31:0] hi_i;
  logic [31:0] lo_i;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [32];
  logic [31:0] hi_m;
  logic [31:0] lo_m;

  regfile dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .hilo_we(hilo_we), .hi_i(hi_i), .lo_i(lo_i), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  // Architectural state advances at each rising edge from the inputs held across it.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      hi_m = 32'h0;
      lo_m = 32'h0;
    end else begin
      if (we && waddr != 5'd0) model[waddr] = wdata;
      if (hilo_we) begin
        hi_m = hi_i;
        lo_m = lo_i;
      end
    end
    #1;
  endtask

  function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] ra);
    if (rst || !re || ra == 5'd0) return 32'h0;
    if (we && waddr == ra) return wdata;
    return model[ra];
  endfunction

  task automatic idle();
    rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
    hilo_we = 1'b0; hi_i = '0; lo_i = '0;
  endtask

  task automatic test_reset();
    idle();
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    tick();
    rst = 1'b1; we = 1'b1; waddr = 5'd6; wdata = 32'hCAFEF00D;
    re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd6;
    hilo_we = 1'b1; hi_i = 32'h11; lo_i = 32'h22;
    #2;
    checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL rst_rdata1 got %h want %h", rdata1, 32'h0); end
    checks++; if (rdata2 !== 32'h0) begin errors++; $display("FAIL rst_rdata2 got %h want %h", rdata2, 32'h0); end
    checks++; if (hi_o !== 32'h0) begin errors++; $display("FAIL rst_hi got %h want %h", hi_o, 32'h0); end
    checks++; if (lo_o !== 32'h0) begin errors++; $display("FAIL rst_lo got %h want %h", lo_o, 32'h0); end
    tick();
    idle();
    re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd6;
    #2;
    checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL post_rst_r5 got %h want %h", rdata1, 32'h0); end
    checks++; if (rdata2 !== 32'h0) begin errors++; $display("FAIL rst_write_lost_r6 got %h want %h", rdata2, 32'h0); end
    tick();
  endtask

  task automatic test_r0();
    idle();
    we = 1'b1; waddr = 5'd0; wdata = 32'h12345678;
    re1 = 1'b1; raddr1 = 5'd0; re2 = 1'b1; raddr2 = 5'd0;
    #2;
    checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL r0_bypass1 got %h want %h", rdata1, 32'h0); end
    checks++; if (rdata2 !== 32'h0) begin errors++; $display("FAIL r0_bypass2 got %h want %h", rdata2, 32'h0); end
    tick();
    we = 1'b0;
    #2;
    checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL r0_read1 got %h want %h", rdata1, 32'h0); end
    checks++; if (rdata2 !== 32'h0) begin errors++; $display("FAIL r0_read2 got %h want %h", rdata2, 32'h0); end
    tick();
  endtask

  task automatic test_basic();
    idle();
    we = 1'b1; waddr = 5'd3; wdata = 32'h00000011;
    tick();
    waddr = 5'd31; wdata = 32'hFFFFFFFF;
    tick();
    idle();
    re1 = 1'b1; raddr1 = 5'd3; re2 = 1'b1; raddr2 = 5'd31;
    #2;
    checks++; if (rdata1 !== 32'h00000011) begin errors++; $display("FAIL basic_r3 got %h want %h", rdata1, 32'h00000011); end
    checks++; if (rdata2 !== 32'hFFFFFFFF) begin errors++; $display("FAIL basic_r31 got %h want %h", rdata2, 32'hFFFFFFFF); end
    tick();
  endtask

  task automatic test_bypass();
    idle();
    we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5;
    re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b1; raddr2 = 5'd7;
    #2;
    checks++; if (rdata1 !== 32'hA5A5A5A5) begin errors++; $display("FAIL bypass1 got %h want %h", rdata1, 32'hA5A5A5A5); end
    checks++; if (rdata2 !== 32'hA5A5A5A5) begin errors++; $display("FAIL bypass2 got %h want %h", rdata2, 32'hA5A5A5A5); end
    re2 = 1'b0;
    #2;
    checks++; if (rdata2 !== 32'h0) begin errors++; $display("FAIL bypass_re2_off got %h want %h", rdata2, 32'h0); end
    tick();
  endtask

  task automatic test_read_disable();
    idle();
    we = 1'b1; waddr = 5'd9; wdata = 32'h55;
    tick();
    idle();
    re1 = 1'b0; raddr1 = 5'd9;
    #2;
    checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL rd_disabled got %h want %h", rdata1, 32'h0); end
    re1 = 1'b1;
    #2;
    checks++; if (rdata1 !== 32'h55) begin errors++; $display("FAIL rd_enabled got %h want %h", rdata1, 32'h55); end
    tick();
  endtask

  task automatic test_hilo();
    idle();
    hilo_we = 1'b1; hi_i = 32'h1; lo_i = 32'h2;
    #2;
    checks++; if (hi_o !== 32'h1) begin errors++; $display("FAIL hilo_byp_hi got %h want %h", hi_o, 32'h1); end
    checks++; if (lo_o !== 32'h2) begin errors++; $display("FAIL hilo_byp_lo got %h want %h", lo_o, 32'h2); end
    tick();
    hilo_we = 1'b0; hi_i = 32'h77; lo_i = 32'h88;
    #2;
    checks++; if (hi_o !== 32'h1) begin errors++; $display("FAIL hilo_hold_hi got %h want %h", hi_o, 32'h1); end
    checks++; if (lo_o !== 32'h2) begin errors++; $display("FAIL hilo_hold_lo got %h want %h", lo_o, 32'h2); end
    tick();
    rst = 1'b1; hilo_we = 1'b1; hi_i = 32'h9; lo_i = 32'hA;
    #2;
    checks++; if (hi_o !== 32'h0) begin errors++; $display("FAIL hilo_rst_hi got %h want %h", hi_o, 32'h0); end
    tick();
    rst = 1'b0; hilo_we = 1'b0;
    #2;
    checks++; if (hi_o !== 32'h0) begin errors++; $display("FAIL hilo_after_rst_hi got %h want %h", hi_o, 32'h0); end
    checks++; if (lo_o !== 32'h0) begin errors++; $display("FAIL hilo_after_rst_lo got %h want %h", lo_o, 32'h0); end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] e1, e2, eh, el;
    for (int n = 0; n < 400; n++) begin
      rst     = ($urandom_range(0, 39) == 0);
      we      = $urandom_range(0, 1);
      waddr   = 5'($urandom_range(0, 31));
      wdata   = $urandom;
      re1     = ($urandom_range(0, 7) != 0);
      re2     = ($urandom_range(0, 7) != 0);
      // Bias reads toward the write address so bypass collisions happen often.
      raddr1  = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      raddr2  = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      hilo_we = ($urandom_range(0, 3) == 0);
      hi_i    = $urandom;
      lo_i    = $urandom;
      #2;
      e1 = exp_rd(re1, raddr1);
      e2 = exp_rd(re2, raddr2);
      eh = rst ? 32'h0 : (hilo_we ? hi_i : hi_m);
      el = rst ? 32'h0 : (hilo_we ? lo_i : lo_m);
      checks++; if (rdata1 !== e1) begin errors++; $display("FAIL rand_rdata1 n=%0d a=%0d got %h want %h", n, raddr1, rdata1, e1); end
      checks++; if (rdata2 !== e2) begin errors++; $display("FAIL rand_rdata2 n=%0d a=%0d got %h want %h", n, raddr2, rdata2, e2); end
      checks++; if (hi_o !== eh) begin errors++; $display("FAIL rand_hi n=%0d got %h want %h", n, hi_o, eh); end
      checks++; if (lo_o !== el) begin errors++; $display("FAIL rand_lo n=%0d got %h want %h", n, lo_o, el); end
      tick();
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    test_reset();
    test_r0();
    test_basic();
    test_bypass();
    test_read_disable();
    test_hilo();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- Architectural general-purpose register file at the consumer end of the MEM/WB writeback interface.
- Accepts the writeback triple (wd, wreg, wdata) from the MEM/WB pipeline register.
- Serves two operand read ports to the ID stage.
- Also holds the HI/LO special-register pair, written from the same writeback path and readable by EX.
- Write-to-read bypass guarantees that an instruction in ID sees a value retiring in the same cycle.

Parameters:
- DATA_W, 32, register data width (matches RegBus).
- ADDR_W, 5, register address width (matches RegAddrBus).
- NUM_REGS, 32, number of GPRs; must equal 2**ADDR_W.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high (RstEnable = 1'b1).
- we  in  1  GPR write enable, driven from wb_wreg.
- waddr  in  ADDR_W  GPR write address, driven from wb_wd.
- wdata  in  DATA_W  GPR write data, driven from wb_wdata.
- re1  in  1  read port 1 enable.
- raddr1  in  ADDR_W  read port 1 address.
- rdata1  out  DATA_W  read port 1 data (combinational).
- re2  in  1  read port 2 enable.
- raddr2  in  ADDR_W  read port 2 address.
- rdata2  out  DATA_W  read port 2 data (combinational).
- hilo_we  in  1  HI/LO write enable from writeback.
- hi_i  in  DATA_W  HI write data.
- lo_i  in  DATA_W  LO write data.
- hi_o  out  DATA_W  current HI, bypassed.
- lo_o  out  DATA_W  current LO, bypassed.

Behaviour:
- Reset: on posedge clk with rst=1, clear all NUM_REGS entries, HI and LO to ZeroWord. Writes presented in that cycle are discarded.
- Outputs under reset: while rst=1, rdata1, rdata2, hi_o and lo_o are forced to ZeroWord, independent of the other inputs.
- GPR write: on posedge clk with rst=0, we=1 and waddr!=0, set mem[waddr] <= wdata. Latency is 1 cycle to storage.
- Register $0: writes to address 0 are dropped. Reads of address 0 always return ZeroWord, including when bypass conditions are met.
- Read port n (combinational), in priority order:
  1. rst=1 -> 0.
  2. ren=0 -> 0.
  3. raddrn=0 -> 0.
  4. we=1 and waddr==raddrn -> wdata (same-cycle write-first bypass).
  5. Otherwise -> mem[raddrn].
- Both read ports are independent. Both may hit the same address, and both may bypass simultaneously.
- HI/LO: on posedge clk with rst=0 and hilo_we=1, set HI <= hi_i and LO <= lo_i.
- HI/LO outputs: hi_o/lo_o = hilo_we ? hi_i : stored value. The same-cycle bypass applies here as well.
- No X propagation: every entry is defined after the first reset cycle.
- Reset mid-operation: a write coincident with rst is lost. The first post-reset cycle reads zeros unless a write in that cycle bypasses.
- Unknown or non-power-of-two NUM_REGS is unsupported; elaboration-time check is optional.

Decomposition:
- The shared defines file holds RegBus, RegAddrBus, RegNum (32), RegNumLog2 (5), ZeroWord, NOPRegAddr, RstEnable, WriteEnable, ReadEnable, ReadDisable. No new constants are introduced locally.
- Sub-module hilo_reg holds the HI/LO pair and its bypass.
  - Ports: clk, rst, we, hi_i, lo_i, hi_o, lo_o.
  - regfile instantiates it once.
  - GPR array and read muxes stay in regfile.

Test Plan:
- Reset clears: write 0xDEADBEEF to r5, then assert rst for 1 cycle and read r5 on port 1 -> 0x00000000. During rst, all four outputs -> 0.
- $0 immutability: we=1, waddr=0, wdata=0x12345678; next cycle read r0 on both ports -> 0x00000000. Same-cycle bypass on r0 -> also 0.
- Basic write/read: write r3=0x00000011 and r31=0xFFFFFFFF in consecutive cycles, then read r3 on port 1 and r31 on port 2 -> 0x00000011 and 0xFFFFFFFF.
- Bypass: we=1, waddr=7, wdata=0xA5A5A5A5 with raddr1=raddr2=7, re1=re2=1 in the same cycle -> both rdata = 0xA5A5A5A5 before the clock edge. With re2=0 -> rdata2=0.
- Read disable: r9 holds 0x55; re1=0, raddr1=9 -> rdata1=0.
- HI/LO: hilo_we=1, hi_i=0x1, lo_i=0x2 -> hi_o/lo_o=1/2 same cycle and hold after. Then rst -> both 0. A coincident hilo_we under rst is discarded.
